keypad_scan_4x4: RTL and testbench
==================================

Name: keypad_scan_4x4

Overview:
- Upstream stage of mm_lock: scans a 4x4 matrix keypad, debounces key presses and releases, and encodes each press as a 4-bit code.
- Each debounced press produces exactly one key_valid pulse, one clk wide, with key_value alongside.
- key_value/key_valid connect directly to mm_lock. Codes A=confirm, B=lock, C=clear, D=change password, E=display password.

Parameters:
- SCAN_DIV, 50000: clk cycles per scan tick; 1 ms at 50 MHz. Minimum 4.
- DEBOUNCE_CNT, 20: consecutive matching ticks needed to accept a press or a release. Minimum 2.
- REPEAT_DELAY, 500: ticks a key is held before the first auto-repeat. Used only with KEYPAD_REPEAT_EN.
- REPEAT_RATE, 100: ticks between auto-repeats. Used only with KEYPAD_REPEAT_EN.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- row  in  4  keypad row lines; active-low; externally pulled up; asynchronous to clk
- col  out 4  keypad column drive; active-low one-hot (exactly one bit 0)
- key_value  out 4  code of the last accepted key
- key_valid  out 1  one-cycle pulse per accepted key

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Input sync: row passes through a 2-flop synchronizer. All decisions use the synchronized row (srow).
- Tick: prescaler counts 0..SCAN_DIV-1 and emits a 1-cycle tick at terminal count. The prescaler runs in every state.
- Key map, row r / col c -> code:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- Reset values:
  - col = 4'b1110
  - key_value = 4'h0, key_valid = 0
  - state = SCAN; all counters = 0
- FSM; all transitions happen only on tick:
  - SCAN:
    - srow == 4'hF: rotate col left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
    - Otherwise: latch srow pattern and column index, deb_cnt = 1, go to DEBOUNCE. col is frozen.
  - DEBOUNCE:
    - srow equals the latched pattern: deb_cnt++. When deb_cnt reaches DEBOUNCE_CNT, go to HELD and register the key.
    - srow differs: go to SCAN without rotating. The same column is re-sampled on the next tick.
  - HELD:
    - srow == 4'hF: deb_cnt = 1, go to RELEASE.
    - Otherwise: stay.
  - RELEASE:
    - srow == 4'hF: deb_cnt++. When deb_cnt reaches DEBOUNCE_CNT, go to SCAN and rotate col.
    - Any row low: go to HELD. No new pulse.
- Key register (on DEBOUNCE -> HELD):
  - key_value = map(lowest low row index in latched pattern, column index). Multiple rows low: lowest row wins.
  - key_valid = 1 on the cycle after the tick, for exactly 1 cycle.
- key_value holds its value until the next accepted key; it is never cleared except by rst.
- Latency: key_valid rises at most (4 + DEBOUNCE_CNT) * SCAN_DIV + 4 cycles after a stable press.
- One press gives one pulse, however long the key is held (unless KEYPAD_REPEAT_EN).
- Bounce shorter than one tick in DEBOUNCE gives no pulse.
- rst asserted mid-operation: everything returns to reset values on the next clk edge. A pending pulse is dropped.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, a tick counter starts at entry.
  - After REPEAT_DELAY ticks, emit a key_valid pulse with the same key_value.
  - Then emit one every REPEAT_RATE ticks while held.
  - The counter clears on leaving HELD. A RELEASE -> HELD bounce restarts the delay.
- Undefined: no repeat logic and no repeat counter. REPEAT_* parameters are ignored.

Test Plan (sim parameters SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_DELAY=5, REPEAT_RATE=2):
- Reset: rst high 3 cycles, then low; no key -> col cycles 1110, 1101, 1011, 0111, changing every 4 clk; key_valid stays 0; key_value = 0.
- Single press: key r1c2 held clean for 40 cycles -> exactly one key_valid pulse with key_value = 4'h6; col frozen at 1011 while held; rotation resumes after a release of at least 3 ticks.
- Bounce: r0c3 toggled every 5 clk for 30 cycles, then held stable -> no pulse during bouncing; exactly one pulse with key_value = 4'hA after the stable hold.
- Lock sequence: press and release 1,2,3,4,5,6,7,8,A in turn -> nine pulses in order with key_value 1..8, then A; no pulse during any release.
- Two rows low together in c1 (r2 and r3) -> single pulse with key_value = 4'h8 (lowest row wins). Assert rst mid-DEBOUNCE -> no pulse; col = 1110 on the next cycle.
- KEYPAD_REPEAT_EN: hold key 0 (r3c1) for 20 ticks -> pulses at acceptance, then at +5, +7, +9 ... ticks, all with key_value = 0. Without the macro -> one pulse only.

Source files
------------

// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: 4x4 matrix keypad scanner with press/release debounce.
// Drives one column low at a time, watches the active-low rows, and emits
// one key_valid pulse with a 4-bit key_value per debounced press.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_4x4 #(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned DEBOUNCE_CNT = 20,
   parameter int unsigned REPEAT_DELAY = 500,
   parameter int unsigned REPEAT_RATE  = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_value,
   output logic       key_valid
);

   localparam int unsigned PW = $clog2(SCAN_DIV);
   localparam int unsigned DW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CNT - 1);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD,
      RELEASE
   } state_t;

   state_t        state;
   logic [3:0]    row_meta;
   logic [3:0]    srow;
   logic [PW-1:0] presc;
   logic          tick;
   logic [1:0]    col_idx;
   logic [3:0]    lat_row;
   logic [1:0]    lat_col;
   logic [DW-1:0] deb_cnt;

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RW = $clog2(REP_MAX + 1);
   localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_RATE);

   logic [RW-1:0] rep_cnt;
   logic          rep_phase;   // 0: waiting for first repeat, 1: periodic
`endif

   // Key map: row r, column c -> code
   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

   // Lowest-indexed low row in an active-low pattern
   function automatic logic [1:0] lowest_row(input logic [3:0] pat);
      logic [1:0] r;
      if (!pat[0])      r = 2'd0;
      else if (!pat[1]) r = 2'd1;
      else if (!pat[2]) r = 2'd2;
      else              r = 2'd3;
      return r;
   endfunction

   assign tick = (presc == PRESC_LAST);

   // Two-flop synchronizer for the asynchronous row lines (idle = pulled high)
   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta <= '1;
         srow     <= '1;
      end else begin
         row_meta <= row;
         srow     <= row_meta;
      end
   end

   // Scan prescaler: free-running 0..SCAN_DIV-1, tick at terminal count
   always_ff @(posedge clk) begin
      if (rst || tick) presc <= '0;
      else             presc <= presc + PW'(1);
   end

   // Scan / debounce / hold / release FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SCAN;
         col       <= 4'b1110;
         col_idx   <= '0;
         lat_row   <= '1;
         lat_col   <= '0;
         deb_cnt   <= '0;
         key_value <= '0;
         key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
`endif
      end else begin
         key_valid <= 1'b0;
         if (tick) begin
            case (state)
               SCAN: begin
                  if (srow == 4'hF) begin
                     col     <= {col[2:0], col[3]};
                     col_idx <= col_idx + 2'd1;
                  end else begin
                     lat_row <= srow;
                     lat_col <= col_idx;
                     deb_cnt <= DW'(1);
                     state   <= DEBOUNCE;
                  end
               end
               DEBOUNCE: begin
                  if (srow == lat_row) begin
                     deb_cnt <= deb_cnt + DW'(1);
                     if (deb_cnt == DEB_LAST) begin
                        state     <= HELD;
                        key_value <= key_code(lowest_row(lat_row), lat_col);
                        key_valid <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt   <= '0;
                        rep_phase <= 1'b0;
`endif
                     end
                  end else begin
                     // Column stays put so the same column is re-sampled
                     state <= SCAN;
                  end
               end
               HELD: begin
                  if (srow == 4'hF) begin
                     deb_cnt <= DW'(1);
                     state   <= RELEASE;
`ifdef KEYPAD_REPEAT_EN
                     rep_cnt   <= '0;
                     rep_phase <= 1'b0;
`endif
                  end else begin
`ifdef KEYPAD_REPEAT_EN
                     if ((rep_cnt + RW'(1)) == (rep_phase ? REP_NEXT : REP_FIRST)) begin
                        key_valid <= 1'b1;
                        rep_cnt   <= '0;
                        rep_phase <= 1'b1;
                     end else begin
                        rep_cnt <= rep_cnt + RW'(1);
                     end
`endif
                  end
               end
               RELEASE: begin
                  if (srow == 4'hF) begin
                     deb_cnt <= deb_cnt + DW'(1);
                     if (deb_cnt == DEB_LAST) begin
                        state   <= SCAN;
                        col     <= {col[2:0], col[3]};
                        col_idx <= col_idx + 2'd1;
                     end
                  end else begin
                     // Release bounce: back to held, no new pulse
                     state <= HELD;
`ifdef KEYPAD_REPEAT_EN
                     rep_cnt   <= '0;
                     rep_phase <= 1'b0;
`endif
                  end
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Self-checking bench for keypad_scan_4x4 (SCAN_DIV=4, DEBOUNCE_CNT=3,
// REPEAT_DELAY=5, REPEAT_RATE=2). A keypad model pulls rows low from a
// 16-bit pressed-key mask; expected key codes go into a queue and are
// popped by a monitor on every key_valid pulse.
module tb_keypad_scan_4x4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_value;
   logic       key_valid;

   logic [15:0] mask;          // bit r*4+c set = key (r,c) pressed
   logic [3:0]  exp_q[$];
   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   typedef struct {
      logic [15:0] mask;
      logic [3:0]  exp_value;
   } vec_t;

   vec_t vecs[18];

   keypad_scan_4x4 #(
      .SCAN_DIV(4),
      .DEBOUNCE_CNT(3),
      .REPEAT_DELAY(5),
      .REPEAT_RATE(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .row(row),
      .col(col),
      .key_value(key_value),
      .key_valid(key_valid)
   );

   always #5 clk = ~clk;

   // Keypad matrix model: a pressed key shorts its row to its driven-low column
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (mask[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   // Scoreboard monitor: every pulse must match the next queued code
   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse: key_valid=1 key_value=%h, required no pulse", key_value);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (key_value !== e) begin
               n_bad++;
               $display("FAIL pulse_value: key_value=%h, required %h", key_value, e);
            end
         end
      end
   end

   task automatic check4(input string name, input logic [3:0] got, input logic [3:0] req);
      n_vec++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got %b, required %b", name, got, req);
      end
   endtask

   task automatic check_drained(input string name);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL %s: %0d expected pulses missing, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   function automatic logic [3:0] rotl(input logic [3:0] v, input int unsigned k);
      logic [3:0] t;
      t = v;
      for (int unsigned i = 0; i < k; i++) t = {t[2:0], t[3]};
      return t;
   endfunction

   initial begin
      int unsigned n_rep;
      bit          seen;

      vecs[0]  = '{16'h0001, 4'h1};
      vecs[1]  = '{16'h0002, 4'h2};
      vecs[2]  = '{16'h0004, 4'h3};
      vecs[3]  = '{16'h0010, 4'h4};
      vecs[4]  = '{16'h0020, 4'h5};
      vecs[5]  = '{16'h0040, 4'h6};
      vecs[6]  = '{16'h0100, 4'h7};
      vecs[7]  = '{16'h0200, 4'h8};
      vecs[8]  = '{16'h0008, 4'hA};
      vecs[9]  = '{16'h0400, 4'h9};
      vecs[10] = '{16'h0080, 4'hB};
      vecs[11] = '{16'h0800, 4'hC};
      vecs[12] = '{16'h1000, 4'hE};
      vecs[13] = '{16'h2000, 4'h0};
      vecs[14] = '{16'h4000, 4'hF};
      vecs[15] = '{16'h8000, 4'hD};
      vecs[16] = '{16'h2200, 4'h8};   // r2 and r3 in c1: lowest row wins
      vecs[17] = '{16'h4004, 4'h3};   // r0 and r3 in c2

      // Reset state
      mask = '0;
      rst  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check4("reset_col", col, 4'b1110);
      check4("reset_key_value", key_value, 4'h0);
      check4("reset_key_valid", {3'b000, key_valid}, 4'h0);
      rst = 1'b0;

      // Idle rotation: column advances every 4 clocks, first after the 4th edge
      for (int unsigned i = 0; i < 16; i++) begin
         @(negedge clk);
         check4("idle_rotation", col, rotl(4'b1110, ((i + 1) / 4) % 4));
      end

      // Single clean press of r1c2 -> 6, column frozen while held
      exp_q.push_back(4'h6);
      mask = 16'h0040;
      repeat (40) @(negedge clk);
      check4("held_col_frozen", col, 4'b1011);
      check_drained("single_press");
      mask = '0;
      seen = 1'b0;
      for (int unsigned i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (col != 4'b1011) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
         n_bad++;
         $display("FAIL rotation_resume: col stuck at %b after release, required rotation", col);
      end
      repeat (40) @(negedge clk);

      // Bounce on r0c3 then a stable hold -> exactly one A
      for (int unsigned k = 0; k < 6; k++) begin
         mask[3] = ~mask[3];
         repeat (5) @(negedge clk);
      end
      exp_q.push_back(4'hA);
      mask = 16'h0008;
      repeat (40) @(negedge clk);
      check_drained("bounce_then_hold");
      mask = '0;
      repeat (40) @(negedge clk);

      // Table: lock sequence, full key map, multi-row presses
      for (int unsigned v = 0; v < 18; v++) begin
         exp_q.push_back(vecs[v].exp_value);
         mask = vecs[v].mask;
         repeat (40) @(negedge clk);
         check_drained("table_press");
         mask = '0;
         repeat (40) @(negedge clk);
      end

      // Reset in the middle of DEBOUNCE on r0c0: pulse dropped, outputs reset
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      mask = 16'h0001;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check4("midreset_col", col, 4'b1110);
      check4("midreset_key_value", key_value, 4'h0);
      check4("midreset_key_valid", {3'b000, key_valid}, 4'h0);
      mask = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);

      // Long hold of key 0 (r3c1): 20 ticks after acceptance
`ifdef KEYPAD_REPEAT_EN
      n_rep = 8;   // repeats at +5,+7,...,+19 ticks
`else
      n_rep = 0;
`endif
      exp_q.push_back(4'h0);
      mask = 16'h2000;
      seen = 1'b0;
      for (int unsigned i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (key_valid === 1'b1) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
         n_bad++;
         $display("FAIL hold_accept_timeout: no key_valid within 60 cycles, required 1 pulse");
      end
      for (int unsigned i = 0; i < n_rep; i++) exp_q.push_back(4'h0);
      repeat (77) @(negedge clk);
      mask = '0;
      repeat (40) @(negedge clk);
      check_drained("long_hold");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
